// File: rtl/lieat_ifu_ibus_arb.sv
// ---------------------------------------------------------------------------
// lieat_ifu_ibus_arb
//
// Instruction-bus arbiter and outstanding-transaction tracker between the
// IFU fetch request stage and one auxiliary requester (fence.i refill /
// debug fetch). One request is granted per cycle onto the single I-bus.
// Each accepted transaction records its owner in an in-order tag FIFO so
// the (in-order) bus response can be routed back. Fetch responses made
// stale by a pipeline flush are discarded.
//
// Handshake rules (all request channels): a transfer happens in a cycle
// where valid and ready are both 1. Requesters hold valid and address
// stable until ready. Response channels have no backpressure: a *_rsp_valid
// pulse is a completed transfer.
//
// Optional feature macro: IBUS_ARB_STARVE_GUARD_EN
//   defined   : aux gains priority after STARVE_MAX consecutive cycles of
//               losing to an accepted fetch.
//   undefined : fetch has strict fixed priority; aux is granted only when
//               no fetch is requesting. STARVE_MAX is unused.
//
// Ports:
//   clock, reset                  clock, async active-high reset
//   fch_req_valid/ready/pc        fetch request channel
//   fch_flush                     kill all in-flight fetch transactions
//   fch_rsp_valid/data/err        fetch response (zero latency from bus)
//   aux_req_valid/ready/addr      aux request channel
//   aux_rsp_valid/data/err        aux response (zero latency from bus)
//   bus_req_valid/ready/addr      I-bus request channel
//   bus_rsp_valid/data/err        I-bus response, in order, no backpressure
//   ost_cnt                       number of in-flight bus transactions
// ---------------------------------------------------------------------------
module lieat_ifu_ibus_arb #(
  parameter int XLEN       = 32,
  parameter int OST_DEPTH  = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fch_req_valid,
  output logic                       fch_req_ready,
  input  logic [XLEN-1:0]            fch_req_pc,
  input  logic                       fch_flush,
  output logic                       fch_rsp_valid,
  output logic [XLEN-1:0]            fch_rsp_data,
  output logic                       fch_rsp_err,
  input  logic                       aux_req_valid,
  output logic                       aux_req_ready,
  input  logic [XLEN-1:0]            aux_req_addr,
  output logic                       aux_rsp_valid,
  output logic [XLEN-1:0]            aux_rsp_data,
  output logic                       aux_rsp_err,
  output logic                       bus_req_valid,
  input  logic                       bus_req_ready,
  output logic [XLEN-1:0]            bus_req_addr,
  input  logic                       bus_rsp_valid,
  input  logic [XLEN-1:0]            bus_rsp_data,
  input  logic                       bus_rsp_err,
  output logic [$clog2(OST_DEPTH):0] ost_cnt
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OST_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (OST_DEPTH < 2 || (OST_DEPTH & (OST_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("OST_DEPTH must be a power of two and at least 2");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  // Tag FIFO storage. tag_live marks occupied slots so a flush can mark
  // every in-flight fetch entry in one cycle without walking the pointers.
  logic [OST_DEPTH-1:0] tag_live;
  logic [OST_DEPTH-1:0] tag_id;    // 0 = fetch, 1 = aux
  logic [OST_DEPTH-1:0] tag_kill;  // fetch response must be dropped
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;

  logic full;
  logic empty;
  logic aux_prio;
  logic grant_fch;
  logic grant_aux;
  logic fch_hs;
  logic aux_hs;
  logic push;
  logic pop;
  logic head_id;
  logic head_kill;

  assign full  = (ost_cnt == DEPTH_C);
  assign empty = (ost_cnt == '0);

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  // Fetch wins unless aux has been promoted; aux still takes an idle bus.
  assign grant_fch = fch_req_valid & ~(aux_prio & aux_req_valid);
  assign grant_aux = aux_req_valid & ~grant_fch;

  // Outputs are forced low while reset is held so no handshake can occur
  // against a FIFO that is being cleared.
  assign bus_req_valid = ~reset & ~full & (fch_req_valid | aux_req_valid);
  assign bus_req_addr  = grant_aux ? aux_req_addr : fch_req_pc;

  assign fch_req_ready = ~reset & grant_fch & bus_req_ready & ~full;
  assign aux_req_ready = ~reset & grant_aux & bus_req_ready & ~full;

  assign fch_hs = fch_req_valid & fch_req_ready;
  assign aux_hs = aux_req_valid & aux_req_ready;
  assign push   = fch_hs | aux_hs;

  // ---------------------------------------------------------------------
  // Response routing (combinational from the bus and the FIFO head)
  // ---------------------------------------------------------------------
  // A response arriving with nothing in flight is a leftover from before
  // a reset and is silently ignored.
  assign pop       = bus_rsp_valid & ~empty;
  assign head_id   = tag_id[rd_ptr];
  assign head_kill = tag_kill[rd_ptr];

  // A flush in the pop cycle also kills the response being returned.
  assign fch_rsp_valid = pop & ~head_id & ~head_kill & ~fch_flush;
  assign fch_rsp_data  = bus_rsp_data;
  assign fch_rsp_err   = bus_rsp_err;

  assign aux_rsp_valid = pop & head_id;
  assign aux_rsp_data  = bus_rsp_data;
  assign aux_rsp_err   = bus_rsp_err;

  // ---------------------------------------------------------------------
  // Tag FIFO and in-flight counter
  // ---------------------------------------------------------------------
  // push and pop never target the same slot: push needs ~full and pop
  // needs ~empty, so equal pointers cannot both be acting in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ost_cnt  <= '0;
      tag_live <= '0;
      tag_id   <= '0;
      tag_kill <= '0;
    end else begin
      // Flush marks entries already in flight; the slot written below in
      // the same cycle holds the redirect fetch and stays live.
      if (fch_flush) begin
        tag_kill <= tag_kill | (tag_live & ~tag_id);
      end
      if (pop) begin
        tag_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        tag_live[wr_ptr] <= 1'b1;
        tag_id[wr_ptr]   <= aux_hs;
        tag_kill[wr_ptr] <= 1'b0;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (push & ~pop) begin
        ost_cnt <= ost_cnt + 1'b1;
      end else if (pop & ~push) begin
        ost_cnt <= ost_cnt - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Aux starvation guard
  // ---------------------------------------------------------------------
`ifdef IBUS_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign aux_prio = (starve_cnt == STARVE_C);

  // Counts consecutive cycles in which aux waited while a fetch was
  // accepted; any cycle where aux is served or idle restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (aux_hs | ~aux_req_valid) begin
      starve_cnt <= '0;
    end else if (fch_hs & (starve_cnt != STARVE_C)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign aux_prio = 1'b0;
`endif

endmodule

// File: tb/tb_lieat_ifu_ibus_arb.sv
// ---------------------------------------------------------------------------
// tb_lieat_ifu_ibus_arb
//
// Self-checking bench for lieat_ifu_ibus_arb. A reference model holds the
// in-flight transactions as a queue of {owner, killed, address} records and
// derives grants, readiness and response routing from the arbitration
// rules. Expected responses are pushed into per-owner queues; a separate
// monitor compares them whenever the DUT raises a response valid.
// ---------------------------------------------------------------------------
module tb_lieat_ifu_ibus_arb;

  localparam int XLEN       = 32;
  localparam int OST_DEPTH  = 4;
  localparam int STARVE_MAX = 8;
  localparam int CW         = $clog2(OST_DEPTH) + 1;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // -------------------------------------------------------------------------
  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            fch_req_valid = 1'b0;
  logic            fch_req_ready;
  logic [XLEN-1:0] fch_req_pc = '0;
  logic            fch_flush = 1'b0;
  logic            fch_rsp_valid;
  logic [XLEN-1:0] fch_rsp_data;
  logic            fch_rsp_err;
  logic            aux_req_valid = 1'b0;
  logic            aux_req_ready;
  logic [XLEN-1:0] aux_req_addr = '0;
  logic            aux_rsp_valid;
  logic [XLEN-1:0] aux_rsp_data;
  logic            aux_rsp_err;
  logic            bus_req_valid;
  logic            bus_req_ready = 1'b0;
  logic [XLEN-1:0] bus_req_addr;
  logic            bus_rsp_valid = 1'b0;
  logic [XLEN-1:0] bus_rsp_data = '0;
  logic            bus_rsp_err = 1'b0;
  logic [CW-1:0]   ost_cnt;

  always #5 clock = ~clock;

  lieat_ifu_ibus_arb #(
    .XLEN(XLEN), .OST_DEPTH(OST_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .fch_req_valid(fch_req_valid), .fch_req_ready(fch_req_ready),
    .fch_req_pc(fch_req_pc), .fch_flush(fch_flush),
    .fch_rsp_valid(fch_rsp_valid), .fch_rsp_data(fch_rsp_data),
    .fch_rsp_err(fch_rsp_err),
    .aux_req_valid(aux_req_valid), .aux_req_ready(aux_req_ready),
    .aux_req_addr(aux_req_addr),
    .aux_rsp_valid(aux_rsp_valid), .aux_rsp_data(aux_rsp_data),
    .aux_rsp_err(aux_rsp_err),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data),
    .bus_rsp_err(bus_rsp_err),
    .ost_cnt(ost_cnt)
  );

  // -------------------------------------------------------------------------
  // Reference model state and scoreboard
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic            id;    // 0 fetch, 1 aux
    logic            kill;
    logic [XLEN-1:0] addr;
  } ent_t;

  ent_t          mq[$];         // transactions in flight, oldest first
  int            starve = 0;    // consecutive contested aux losses
  logic [XLEN:0] fch_exp_q[$];  // {err, data}
  logic [XLEN:0] aux_exp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Driver: applies one cycle of inputs, checks request-side outputs
  // against the model, pushes expected responses and advances the model.
  // -------------------------------------------------------------------------
  task automatic do_cycle(input logic fv, input logic [XLEN-1:0] pc,
                          input logic av, input logic [XLEN-1:0] aa,
                          input logic brdy, input logic rv, input logic fl,
                          input logic rst, output logic f_hs, output logic a_hs);
    logic full, prio, win_aux, exp_bv;
    ent_t e;
    @(posedge clock);
    #1;
    reset         = rst;
    fch_req_valid = fv;
    fch_req_pc    = pc;
    aux_req_valid = av;
    aux_req_addr  = aa;
    bus_req_ready = brdy;
    bus_rsp_valid = rv;
    fch_flush     = fl;
    // The bus returns a word derived from the address it was asked for.
    if (mq.size() != 0) begin
      bus_rsp_data = mq[0].addr ^ 32'h8000_0013;
      bus_rsp_err  = mq[0].addr[2];
    end else begin
      bus_rsp_data = $urandom;
      bus_rsp_err  = 1'($urandom_range(0, 1));
    end

    @(negedge clock);
    if (rst) begin
      mq.delete();
      starve = 0;
    end
    full = (mq.size() == OST_DEPTH);
`ifdef IBUS_ARB_STARVE_GUARD_EN
    prio = (starve == STARVE_MAX);
`else
    prio = 1'b0;
`endif
    win_aux = av && (prio || !fv);
    exp_bv  = !rst && !full && (fv || av);
    f_hs    = exp_bv && !win_aux && brdy;
    a_hs    = exp_bv && win_aux && brdy;

    check("bus_req_valid", 64'(bus_req_valid), 64'(exp_bv));
    check("fch_req_ready", 64'(fch_req_ready), 64'(f_hs));
    check("aux_req_ready", 64'(aux_req_ready), 64'(a_hs));
    check("ost_cnt", 64'(ost_cnt), 64'(mq.size()));
    if (exp_bv) check("bus_req_addr", 64'(bus_req_addr), 64'(win_aux ? aa : pc));

    if (!rst) begin
      if (rv && mq.size() != 0) begin
        e = mq.pop_front();
        if (e.id) aux_exp_q.push_back({bus_rsp_err, bus_rsp_data});
        else if (!e.kill && !fl) fch_exp_q.push_back({bus_rsp_err, bus_rsp_data});
      end
      if (fl) foreach (mq[i]) if (!mq[i].id) mq[i].kill = 1'b1;
      if (f_hs) mq.push_back('{id: 1'b0, kill: 1'b0, addr: pc});
      if (a_hs) mq.push_back('{id: 1'b1, kill: 1'b0, addr: aa});
      if (!av || a_hs) starve = 0;
      else if (f_hs && starve < STARVE_MAX) starve++;
    end
  endtask

  task automatic idle(input logic rv);
    logic fh, ah;
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, rv, 1'b0, 1'b0, fh, ah);
  endtask

  task automatic drain();
    for (int i = 0; i < OST_DEPTH + 4 && mq.size() != 0; i++) idle(1'b1);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: compares every presented response against the scoreboard.
  // -------------------------------------------------------------------------
  initial begin
    logic [XLEN:0] e;
    forever begin
      @(negedge clock);
      #2;
      check("fch_rsp_valid", 64'(fch_rsp_valid), 64'(fch_exp_q.size() != 0));
      if (fch_rsp_valid === 1'b1 && fch_exp_q.size() != 0) begin
        e = fch_exp_q.pop_front();
        check("fch_rsp_data", 64'({fch_rsp_err, fch_rsp_data}), 64'(e));
      end
      fch_exp_q.delete();
      check("aux_rsp_valid", 64'(aux_rsp_valid), 64'(aux_exp_q.size() != 0));
      if (aux_rsp_valid === 1'b1 && aux_exp_q.size() != 0) begin
        e = aux_exp_q.pop_front();
        check("aux_rsp_data", 64'({aux_rsp_err, aux_rsp_data}), 64'(e));
      end
      aux_exp_q.delete();
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic            fv, av, fh, ah, brdy, rv, fl;
    logic [XLEN-1:0] pc, aa;
    int              first_aux;

    // Reset held with both requesters active: nothing may be offered.
    do_cycle(1'b1, 32'h8000_0000, 1'b1, 32'h9000_0000, 1'b1, 1'b0, 1'b0, 1'b1, fh, ah);
    check("reset_bus_req_valid", 64'(bus_req_valid), 64'd0);
    idle(1'b0);

    // Single fetch, response two cycles after the request.
    do_cycle(1'b1, 32'h8000_0000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    check("single_addr", 64'(bus_req_addr), 64'h8000_0000);
    idle(1'b0);
    check("single_ost", 64'(ost_cnt), 64'd1);
    idle(1'b1);
    check("single_rsp_data", 64'(fch_rsp_data), 64'h13);
    idle(1'b0);
    check("single_ost_end", 64'(ost_cnt), 64'd0);

    // Fill the FIFO, then one response reopens the bus next cycle.
    pc = 32'h8000_0040;
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, pc, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
      if (fh) pc += 4;
    end
    check("fill_ost", 64'(ost_cnt), 64'd4);
    check("fill_ready", 64'(fch_req_ready), 64'd0);
    check("fill_bus_valid", 64'(bus_req_valid), 64'd0);
    do_cycle(1'b1, pc, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b1, pc, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    check("fill_reopen", 64'(fch_req_ready), 64'd1);
    drain();

    // Flush kills three in-flight fetches but not the redirect.
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 32'h8000_0000 + 32'(i * 4), 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b1, 32'h8000_0100, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, fh, ah);
    for (int i = 0; i < 3; i++) idle(1'b1);
    idle(1'b1);
    check("flush_redirect_rsp", 64'(fch_rsp_valid), 64'd1);

    // Mixed fetch/aux/fetch, then flush; only the aux response survives.
    do_cycle(1'b1, 32'h8000_0200, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b0, '0, 1'b1, 32'h9000_0010, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b1, 32'h8000_0204, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, fh, ah);
    idle(1'b1);
    idle(1'b1);
    check("mixed_aux_rsp", 64'(aux_rsp_valid), 64'd1);
    idle(1'b1);

    // Starvation: both requesters valid continuously.
    first_aux = 0;
    pc = 32'h8000_1000;
    for (int c = 1; c <= 12; c++) begin
      do_cycle(1'b1, pc, 1'b1, 32'h9000_0100, 1'b1, mq.size() != 0, 1'b0, 1'b0, fh, ah);
      if (fh) pc += 4;
      if (ah && first_aux == 0) first_aux = c;
    end
`ifdef IBUS_ARB_STARVE_GUARD_EN
    check("starve_first_aux_cycle", 64'(first_aux), 64'd9);
`else
    check("starve_first_aux_cycle", 64'(first_aux), 64'd0);
`endif
    drain();
    idle(1'b0);

    // Reset mid-operation, then stale bus responses.
    do_cycle(1'b1, 32'h8000_2000, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b1, 32'h8000_2004, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, fh, ah);
    do_cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, fh, ah);
    check("midreset_ost", 64'(ost_cnt), 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomized traffic.
    fv = 1'b0; av = 1'b0; fh = 1'b0; ah = 1'b0; pc = '0; aa = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(fv && !fh)) begin
        fv = ($urandom_range(0, 3) != 0);
        pc = $urandom & 32'hFFFF_FFFC;
      end
      if (!(av && !ah)) begin
        av = ($urandom_range(0, 2) == 0);
        aa = $urandom & 32'hFFFF_FFFC;
      end
      brdy = ($urandom_range(0, 3) != 0);
      rv   = (mq.size() != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
      fl   = ($urandom_range(0, 15) == 0);
      do_cycle(fv, pc, av, aa, brdy, rv, fl, 1'b0, fh, ah);
    end
    drain();
    idle(1'b0);

    @(negedge clock);
    #3;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
